// File: rtl/pow_pkg.sv
// Shared types and default widths for the square-and-multiply power engine.
package pow_pkg;

    localparam int BASE_W_D = 4;
    localparam int EXP_W_D  = 4;
    localparam int RES_W_D  = 32;

    localparam logic [RES_W_D-1:0] RES_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pow_state_t;

endpackage

// File: rtl/pow_sat_mul.sv
// Combinational RES_W x RES_W multiply, saturating to all-ones on overflow.
module pow_sat_mul #(
    parameter int RES_W = 32
) (
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    output logic [RES_W-1:0] p,
    output logic             ovf
);

    logic [2*RES_W-1:0] full;

    always_comb begin
        full = {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
        ovf  = |full[2*RES_W-1:RES_W];
        p    = ovf ? {RES_W{1'b1}} : full[RES_W-1:0];
    end

endmodule

// File: rtl/pow_engine.sv
// Sequential base^exp by LSB-first square-and-multiply, fixed EXP_W-cycle run,
// valid/ready on both sides and a sticky saturating overflow flag.
module pow_engine
    import pow_pkg::*;
#(
    parameter int BASE_W = BASE_W_D,
    parameter int EXP_W  = EXP_W_D,
    parameter int RES_W  = RES_W_D
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [BASE_W-1:0] base_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_out,
    output logic              res_ovf
);

    localparam int STEP_W = $clog2(EXP_W + 1);

    pow_state_t state, state_nx;

    logic [RES_W-1:0]  acc, sq, res_q;
    logic [EXP_W-1:0]  e;
    logic [STEP_W-1:0] step;
    logic              ovf, sq_big, res_ovf_q;

    logic [RES_W-1:0]  acc_p, sq_p, acc_nx;
    logic              acc_o, sq_o, ovf_nx, last;

    pow_sat_mul #(.RES_W(RES_W)) u_acc_mul (
        .a   (acc),
        .b   (sq),
        .p   (acc_p),
        .ovf (acc_o)
    );

    pow_sat_mul #(.RES_W(RES_W)) u_sq_mul (
        .a   (sq),
        .b   (sq),
        .p   (sq_p),
        .ovf (sq_o)
    );

    assign last = (step == STEP_W'(EXP_W - 1));

    // A saturated square is only harmless if the accumulator is zero.
    always_comb begin
        acc_nx = acc;
        ovf_nx = ovf;
        if (e[0] && !ovf) begin
            if (acc_o || (sq_big && acc != '0)) begin
                acc_nx = {RES_W{1'b1}};
                ovf_nx = 1'b1;
            end else begin
                acc_nx = acc_p;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_valid) state_nx = RUN;
            RUN:  if (last)        state_nx = DONE;
            DONE: if (res_ready)   state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc       <= '0;
            sq        <= '0;
            e         <= '0;
            step      <= '0;
            ovf       <= 1'b0;
            sq_big    <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        acc    <= RES_W'(1);
                        sq     <= {{(RES_W-BASE_W){1'b0}}, base_in};
                        e      <= exp_in;
                        step   <= '0;
                        ovf    <= 1'b0;
                        sq_big <= 1'b0;
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    ovf  <= ovf_nx;
                    sq   <= sq_p;
                    e    <= e >> 1;
                    step <= step + STEP_W'(1);
                    if (sq_o) sq_big <= 1'b1;
                    if (last) begin
                        res_q     <= acc_nx;
                        res_ovf_q <= ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign res_out     = res_q;
    assign res_ovf     = res_ovf_q;

endmodule

// File: doc/pow_engine.md
Name: pow_engine

Overview:
Sequential integer exponentiation unit computing base^exp by LSB-first square-and-multiply. It is the RTL counterpart of the $pow_x C model used in the load-counter bench, and sits downstream of the load counter: it consumes an operand pair and returns a result over a valid/ready handshake. Fixed latency, one operation in flight, saturating overflow flag.

Parameters:
BASE_W, 4, width of base operand (unsigned)
EXP_W, 4, width of exponent operand (unsigned); also the iteration count
RES_W, 32, width of result; results >= 2^RES_W saturate

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  synchronous active-low reset
start_valid  input  1  operand pair valid
start_ready  output  1  engine can accept operands (high only in IDLE)
base_in  input  BASE_W  base, unsigned
exp_in  input  EXP_W  exponent, unsigned
res_valid  output  1  result valid (high only in DONE)
res_ready  input  1  consumer accepts result
res_out  output  RES_W  base^exp, or all-ones if overflowed
res_ovf  output  1  true result exceeded RES_W bits

Behaviour:
- Clock/reset: one clock clk; reset is synchronous, active-low (resetn sampled on rising clk edge).
- Reset (resetn=0 at an edge): state=IDLE, start_ready=1, res_valid=0, res_out=0, res_ovf=0; internal acc/sq/exp/step cleared. Reset mid-RUN or mid-DONE aborts; operation discarded, no result emitted.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On edge with start_valid=1: acc<=1, sq<=zero-extended base_in, e<=exp_in, step<=0, ovf<=0, sq_big<=0, go RUN. Operands sampled only at that edge.
- RUN: start_ready=0. Each edge: if e[0]: acc<=acc*sq (full 2*RES_W product); if product >= 2^RES_W or (sq_big and acc!=0), set ovf and acc<=all-ones. sq<=sq*sq, saturating; sq_big set sticky if square >= 2^RES_W. e<=e>>1; step++. After EXP_W iterations go DONE.
- Once ovf is set, acc stays all-ones (further multiplies ignored).
- Latency: accept at edge k -> res_valid high after edge k+EXP_W (EXP_W=4: 4 cycles). Independent of operand values.
- DONE: res_valid=1, res_out=acc, res_ovf=ovf, held stable until res_ready=1 at an edge; then IDLE. start_valid in DONE is ignored (start_ready=0).
- Back-to-back: accept on the first edge after returning to IDLE; min issue interval EXP_W+2 cycles.
- Boundary values: 0^0=1, x^0=1, 0^n=0 (n>0), 1^n=1, never overflow. 15^8=0x98C29B81, no overflow. 15^9 and above overflow.
- res_out/res_ovf outside DONE hold last result (0 after reset). Consumers must qualify with res_valid.

Decomposition:
- Package pow_pkg: state enum (IDLE, RUN, DONE), default widths, saturation constant RES_MAX = all-ones RES_W.
- One natural sub-module: pow_sat_mul, combinational RES_W x RES_W multiply with saturate and overflow flag, instantiated twice (acc*sq, sq*sq).
- FSM, counters and handshake stay in pow_engine.

Test Plan:
- Reset, then base=2, exp=10 with start_valid for 1 cycle -> res_valid after exactly 4 edges, res_out=1024 (0x400), res_ovf=0. Matches $pow_x(2,10).
- base=3, exp=0; then base=0, exp=0; then base=0, exp=5 -> res_out 1, 1, 0; res_ovf=0 each.
- base=15, exp=8 -> res_out=0x98C29B81, res_ovf=0. base=15, exp=9 -> res_out=0xFFFFFFFF, res_ovf=1. base=15, exp=15 -> same.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_valid, res_out and res_ovf stay stable, start_ready=0 throughout. New start_valid is ignored. res_ready=1 -> IDLE next edge.
- Reset mid-RUN: resetn=0 at 2nd RUN edge -> next cycle start_ready=1, res_valid=0, res_out=0. A fresh 2^3 then returns 8.
- Random sweep of all 256 (base, exp) pairs, res_ready randomly toggled -> every result matches the $pow_x reference with saturation applied; latency is always 4.
